// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered occupancy/threshold flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered read.
module param_sync_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 14,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     over_flow,
  output logic                     under_flow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] AfC    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AeC    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q, afull_q, aempty_q;
  logic             over_flow_q, under_flow_q;
  logic             wr_acc, rd_acc;

  // Acceptance uses the registered (pre-edge) flags.
  assign wr_acc = wr_en & ~full_q;
  assign rd_acc = rd_en & ~empty_q;

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      afull_q      <= (AF_THRESH == 0);
      aempty_q     <= 1'b1;
      over_flow_q  <= 1'b0;
      under_flow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q      <= count_d;
      full_q       <= (count_d == DepthC);
      empty_q      <= (count_d == '0);
      afull_q      <= (count_d >= AfC);
      aempty_q     <= (count_d <= AeC);
      over_flow_q  <= wr_en & full_q;
      under_flow_q <= rd_en & empty_q;
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_acc && res) mem[wr_ptr_q] <= wdata;
  end

`ifdef FIFO_FWFT_EN
  assign rdata = empty_q ? '0 : mem[rd_ptr_q];
`else
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rdata_q <= '0;
    end else if (rd_acc) begin
      rdata_q <= mem[rd_ptr_q];
    end
  end

  assign rdata = rdata_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign over_flow    = over_flow_q;
  assign under_flow   = under_flow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo (WIDTH=8, DEPTH=16, AF=14, AE=2).
// Builds with or without FIFO_FWFT_EN; rdata expectations follow the selected mode.
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       full, empty, almost_full, almost_empty, over_flow, under_flow;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic [7:0] popped;

  param_sync_fifo #(
    .WIDTH     (8),
    .DEPTH     (16),
    .AF_THRESH (14),
    .AE_THRESH (2)
  ) dut (
    .clk          (clk),
    .res          (res),
    .wr_en        (wr_en),
    .wdata        (wdata),
    .rd_en        (rd_en),
    .rdata        (rdata),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .over_flow    (over_flow),
    .under_flow   (under_flow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_ae"}, 32'(almost_empty), 1);
    check({tag, "_af"}, 32'(almost_full), 0);
    check({tag, "_ovf"}, 32'(over_flow), 0);
    check({tag, "_udf"}, 32'(under_flow), 0);
    check({tag, "_rdata"}, 32'(rdata), 0);
  endtask

  initial begin
    // Reset state
    cyc();
    cyc();
    check_reset_outputs("rst");
    res = 1'b1;

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wdata = 8'(i);
      cyc();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_af", 32'(almost_full), 32'(i + 1 >= 14));
      check("fill_full", 32'(full), 32'(i == 15));
    end
    wdata = 8'hAA;
    cyc();
    check("ovf_pulse", 32'(over_flow), 1);
    check("ovf_count", 32'(count), 16);
    wr_en = 1'b0;
    cyc();
    check("ovf_end", 32'(over_flow), 0);
    check("ovf_count2", 32'(count), 16);

    // Drain 16 words
    for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
      check("drain_rdata", 32'(rdata), 32'(i));
`endif
      rd_en = 1'b1;
      cyc();
`ifndef FIFO_FWFT_EN
      check("drain_rdata", 32'(rdata), 32'(i));
`endif
      check("drain_count", 32'(count), 32'(15 - i));
      check("drain_ae", 32'(almost_empty), 32'(15 - i <= 2));
      check("drain_empty", 32'(empty), 32'(i == 15));
    end
    cyc();
    check("udf_pulse", 32'(under_flow), 1);
    check("udf_count", 32'(count), 0);
`ifdef FIFO_FWFT_EN
    check("udf_rdata", 32'(rdata), 0);
`else
    check("udf_rdata", 32'(rdata), 32'h0F);
`endif
    rd_en = 1'b0;
    cyc();
    check("udf_end", 32'(under_flow), 0);

    // 40 writes / 40 reads at occupancy 5, wrapping pointers twice
    for (int k = 0; k < 5; k++) begin
      wr_en = 1'b1;
      wdata = 8'(8'h40 + k);
      exp_q.push_back(wdata);
      cyc();
    end
    check("il_fill", 32'(count), 5);
    for (int k = 0; k < 35; k++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      wdata = 8'(8'h45 + k);
`ifdef FIFO_FWFT_EN
      check("il_rdata", 32'(rdata), 32'(exp_q[0]));
`endif
      exp_q.push_back(wdata);
      popped = exp_q.pop_front();
      cyc();
`ifndef FIFO_FWFT_EN
      check("il_rdata", 32'(rdata), 32'(popped));
`endif
      check("il_count", 32'(count), 5);
    end
    wr_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
`ifdef FIFO_FWFT_EN
      check("il_tail", 32'(rdata), 32'(exp_q[0]));
`endif
      popped = exp_q.pop_front();
      cyc();
`ifndef FIFO_FWFT_EN
      check("il_tail", 32'(rdata), 32'(popped));
`endif
    end
    rd_en = 1'b0;
    check("il_empty", 32'(empty), 1);

    // Simultaneous read/write while full: read wins, 0x55 dropped
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata = 8'(i);
      cyc();
    end
    check("fr_full", 32'(full), 1);
    wdata = 8'h55;
    rd_en = 1'b1;
`ifdef FIFO_FWFT_EN
    check("fr_rdata", 32'(rdata), 0);
`endif
    cyc();
    check("fr_ovf", 32'(over_flow), 1);
    check("fr_count", 32'(count), 15);
    check("fr_notfull", 32'(full), 0);
`ifndef FIFO_FWFT_EN
    check("fr_rdata", 32'(rdata), 0);
`endif
    wr_en = 1'b0;
    for (int i = 1; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
      check("fr_drain", 32'(rdata), 32'(i));
`endif
      cyc();
`ifndef FIFO_FWFT_EN
      check("fr_drain", 32'(rdata), 32'(i));
`endif
    end
    rd_en = 1'b0;
    check("fr_empty", 32'(empty), 1);

    // Simultaneous read/write while empty: write wins
    wr_en = 1'b1;
    rd_en = 1'b1;
    wdata = 8'h99;
    cyc();
    check("er_udf", 32'(under_flow), 1);
    check("er_ovf", 32'(over_flow), 0);
    check("er_count", 32'(count), 1);
    wr_en = 1'b0;
`ifdef FIFO_FWFT_EN
    check("er_rdata", 32'(rdata), 32'h99);
`endif
    cyc();
`ifndef FIFO_FWFT_EN
    check("er_rdata", 32'(rdata), 32'h99);
`endif
    check("er_count2", 32'(count), 0);
    rd_en = 1'b0;

    // Asynchronous reset mid-burst at count 7
    wr_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wdata = 8'(8'h20 + i);
      cyc();
    end
    check("mr_count", 32'(count), 7);
    wdata = 8'h77;
    #2;
    res = 1'b0;
    #1;
    check_reset_outputs("mr_async");
    cyc();
    check("mr_edge_count", 32'(count), 0);
    wr_en = 1'b0;
    res = 1'b1;
    cyc();
    check("mr_idle_count", 32'(count), 0);
    wr_en = 1'b1;
    wdata = 8'h33;
    cyc();
    check("mr_wr_count", 32'(count), 1);
    wr_en = 1'b0;
    rd_en = 1'b1;
`ifdef FIFO_FWFT_EN
    check("mr_rdata", 32'(rdata), 32'h33);
`endif
    cyc();
`ifndef FIFO_FWFT_EN
    check("mr_rdata", 32'(rdata), 32'h33);
`endif
    check("mr_empty", 32'(empty), 1);
    rd_en = 1'b0;

`ifdef FIFO_FWFT_EN
    // Fall-through of a word written into an empty FIFO
    wr_en = 1'b1;
    wdata = 8'h7E;
    cyc();
    wr_en = 1'b0;
    check("ft_empty", 32'(empty), 0);
    check("ft_rdata", 32'(rdata), 32'h7E);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    check("ft_empty2", 32'(empty), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
